// File: rtl/music_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : music_sequencer
// Purpose  : Steps through the intro/body/outro sections on quarter-beat ticks
//            and muxes the matching ROM tone. Define NOTE_GAP_EN to silence
//            the tail of every beat.
// Revision : 1.0
// ============================================================================
module music_sequencer #(
    parameter int          BEAT_DIV  = 12500000,
    parameter int          INTRO_LEN = 64,
    parameter int          BODY_LEN  = 128,
    parameter int          OUTRO_LEN = 64,
    parameter logic [31:0] SILENCE   = 32'd20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        loop_en,
    input  logic [31:0] tone_intro,
    input  logic [31:0] tone_body,
    input  logic [31:0] tone_outro,
    output logic [7:0]  beat_num,
    output logic [1:0]  section,
    output logic [31:0] tone,
    output logic        playing,
    output logic        done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_INTRO = 2'd1;
    localparam logic [1:0] c_BODY  = 2'd2;
    localparam logic [1:0] c_OUTRO = 2'd3;

    localparam int                 c_DIV_W      = $clog2(BEAT_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(BEAT_DIV - 1);
    localparam logic [7:0]         c_INTRO_LAST = 8'(INTRO_LEN - 1);
    localparam logic [7:0]         c_BODY_LAST  = 8'(BODY_LEN - 1);
    localparam logic [7:0]         c_OUTRO_LAST = 8'(OUTRO_LEN - 1);

    logic [1:0]         r_section;
    logic [7:0]         r_beat;
    logic [c_DIV_W-1:0] r_div;
    logic               r_done;

    logic w_run;
    logic w_tick;
    logic w_last;
    logic w_gap;

    assign w_run  = (r_section != c_IDLE) && !pause;
    assign w_tick = w_run && (r_div == c_DIV_LAST);

    always_comb begin
        w_last = 1'b0;
        case (r_section)
            c_INTRO: w_last = (r_beat == c_INTRO_LAST);
            c_BODY:  w_last = (r_beat == c_BODY_LAST);
            c_OUTRO: w_last = (r_beat == c_OUTRO_LAST);
            default: w_last = 1'b0;
        endcase
    end

`ifdef NOTE_GAP_EN
    // Gap covers the last eighth of the beat, never less than one cycle.
    localparam int                 c_GAP_LEN   = (BEAT_DIV / 8 > 0) ? BEAT_DIV / 8 : 1;
    localparam logic [c_DIV_W-1:0] c_GAP_START = c_DIV_W'(BEAT_DIV - c_GAP_LEN);
    assign w_gap = (r_div >= c_GAP_START);
`else
    assign w_gap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_section <= c_IDLE;
            r_beat    <= 8'd0;
            r_div     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_section <= c_IDLE;
                r_beat    <= 8'd0;
                r_div     <= '0;
            end else if (start && (r_section == c_IDLE)) begin
                r_section <= c_INTRO;
                r_beat    <= 8'd0;
                r_div     <= '0;
            end else if (w_tick) begin
                r_div <= '0;
                if (w_last) begin
                    r_beat <= 8'd0;
                    case (r_section)
                        c_INTRO: r_section <= c_BODY;
                        c_BODY:  r_section <= loop_en ? c_BODY : c_OUTRO;
                        default: begin
                            r_section <= c_IDLE;
                            r_done    <= 1'b1;
                        end
                    endcase
                end else begin
                    r_beat <= r_beat + 8'd1;
                end
            end else if (w_run) begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    always_comb begin
        tone = SILENCE;
        if (w_run && !w_gap) begin
            case (r_section)
                c_INTRO: tone = tone_intro;
                c_BODY:  tone = tone_body;
                c_OUTRO: tone = tone_outro;
                default: tone = SILENCE;
            endcase
        end
    end

    assign beat_num = r_beat;
    assign section  = r_section;
    assign playing  = (r_section != c_IDLE);
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_music_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_music_sequencer
// Purpose  : Directed vector table plus hand sequences for music_sequencer.
// Revision : 1.0
// ============================================================================
module tb_music_sequencer;

    localparam int          c_BD      = 4;
    localparam logic [31:0] c_SILENCE = 32'd20000;
    localparam logic [31:0] c_T_INTRO = 32'd523;
    localparam logic [31:0] c_T_BODY  = 32'd880;
    localparam logic [31:0] c_T_OUTRO = 32'd1046;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, pause, loop_en;
    logic [31:0] tone_intro, tone_body, tone_outro;
    logic [7:0]  beat_num;
    logic [1:0]  section;
    logic [31:0] tone;
    logic        playing;
    logic        done;

    int checks   = 0;
    int failures = 0;

    music_sequencer #(
        .BEAT_DIV (c_BD),
        .INTRO_LEN(4),
        .BODY_LEN (8),
        .OUTRO_LEN(4),
        .SILENCE  (c_SILENCE)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .loop_en   (loop_en),
        .tone_intro(tone_intro),
        .tone_body (tone_body),
        .tone_outro(tone_outro),
        .beat_num  (beat_num),
        .section   (section),
        .tone      (tone),
        .playing   (playing),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sec;
        logic [7:0] beat;
        logic       gap;
        logic       done;
    } st_t;

    typedef struct {
        logic start;
        logic stop;
        logic pause;
        logic loop_en;
        st_t  exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected state k cycles after the start edge, with P body passes.
    function automatic st_t model(input int k, input int p);
        st_t s;
        int  b_end;
        b_end  = 16 + 32 * p;
        s.gap  = ((k % c_BD) == c_BD - 1);
        s.done = 1'b0;
        if (k < 16) begin
            s.sec  = 2'd1;
            s.beat = 8'(k / 4);
        end else if (k < b_end) begin
            s.sec  = 2'd2;
            s.beat = 8'(((k - 16) % 32) / 4);
        end else if (k < b_end + 16) begin
            s.sec  = 2'd3;
            s.beat = 8'((k - b_end) / 4);
        end else begin
            s.sec  = 2'd0;
            s.beat = 8'd0;
            s.gap  = 1'b0;
            s.done = (k == b_end + 16);
        end
        return s;
    endfunction

    function automatic logic [31:0] exp_tone(input st_t s);
`ifdef NOTE_GAP_EN
        if (s.gap) return c_SILENCE;
`endif
        case (s.sec)
            2'd1:    return c_T_INTRO;
            2'd2:    return c_T_BODY;
            2'd3:    return c_T_OUTRO;
            default: return c_SILENCE;
        endcase
    endfunction

    task automatic check_state(input string tag, input st_t s);
        chk({tag, ".section"}, 32'(section), 32'(s.sec));
        chk({tag, ".beat"},    32'(beat_num), 32'(s.beat));
        chk({tag, ".tone"},    tone, exp_tone(s));
        chk({tag, ".playing"}, 32'(playing), 32'(s.sec != 2'd0));
        chk({tag, ".done"},    32'(done), 32'(s.done));
    endtask

    task automatic check_idle(input string tag);
        st_t s;
        s.sec = 2'd0; s.beat = 8'd0; s.gap = 1'b0; s.done = 1'b0;
        check_state(tag, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   done_seen;
        st_t  s;

        tone_intro = c_T_INTRO;
        tone_body  = c_T_BODY;
        tone_outro = c_T_OUTRO;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        repeat (3) step();
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("post_reset");

        // Full plays: one body pass, then two passes with loop_en over the first body end.
        for (int p = 1; p <= 2; p++) begin
            for (int k = 0; k <= 16 + 32 * p + 17; k++) begin
                v.start   = (k == 0);
                v.stop    = 1'b0;
                v.pause   = 1'b0;
                v.loop_en = (p > 1) && (k <= 16 + 32 * (p - 1));
                v.exp     = model(k, p);
                tbl.push_back(v);
            end
        end
        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].start; stop = tbl[i].stop;
            pause = tbl[i].pause; loop_en = tbl[i].loop_en;
            step();
            check_state($sformatf("vec%0d", i), tbl[i].exp);
        end
        start = 1'b0; loop_en = 1'b0;

        // Pause at intro beat 2, divider 1.
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 9; k++) step();
        check_state("pre_pause", model(9, 1));
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("pause%0d.beat", i), 32'(beat_num), 32'd2);
            chk($sformatf("pause%0d.section", i), 32'(section), 32'd1);
            chk($sformatf("pause%0d.tone", i), tone, c_SILENCE);
        end
        pause = 1'b0;
        step(); chk("resume1.beat", 32'(beat_num), 32'd2);
        step(); chk("resume2.beat", 32'(beat_num), 32'd2);
        step(); check_state("resume3", model(12, 1));
        stop = 1'b1; step(); stop = 1'b0;
        check_idle("stop_after_pause");

        // Pause in IDLE is inert; start while paused freezes at intro beat 0.
        pause = 1'b1;
        repeat (3) step();
        check_idle("pause_idle");
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("frozen%0d.section", i), 32'(section), 32'd1);
            chk($sformatf("frozen%0d.beat", i), 32'(beat_num), 32'd0);
            chk($sformatf("frozen%0d.tone", i), tone, c_SILENCE);
            step();
        end
        pause = 1'b0;
        step(); check_state("unfreeze1", model(1, 1));
        step(); check_state("unfreeze2", model(2, 1));
        step(); check_state("unfreeze3", model(3, 1));
        step(); check_state("unfreeze4", model(4, 1));
        stop = 1'b1; step(); stop = 1'b0;
        check_idle("stop_unfreeze");

        // Stop during body beat 5; done must never follow.
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 37; k++) step();
        check_state("body5", model(37, 1));
        stop = 1'b1; step(); stop = 1'b0;
        check_idle("stop_body");
        done_seen = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done) done_seen++;
        end
        chk("stop_no_done", 32'(done_seen), 32'd0);

        // Simultaneous stop and start from IDLE stays IDLE.
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check_idle("stop_start_idle");
        repeat (3) step();
        check_idle("stop_start_idle_later");

        // Start pulse inside the outro is ignored.
        start = 1'b1; step(); start = 1'b0;
        check_state("outro_run0", model(0, 1));
        for (int k = 1; k <= 65; k++) begin
            start = (k == 51);
            step();
            check_state($sformatf("outro_run%0d", k), model(k, 1));
        end
        start = 1'b0;

        // Asynchronous reset mid-play.
        start = 1'b1; step(); start = 1'b0;
        repeat (20) step();
        #2 rst = 1'b1;
        #1;
        check_idle("async_reset");
        step();
        rst = 1'b0;
        step();
        check_idle("after_async_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Plays a song as three sections (intro, body, outro), each held in its own combinational beat-indexed tone ROM.
- Produces the quarter-beat index `beat_num` that addresses all three ROMs.
- Selects which ROM's tone drives the shared buzzer/PWM tone generator.
- Handles start, pause, stop and body looping. Sits between the top-level control FSM and the tone generator.

Parameters:
- BEAT_DIV, 12500000, clk cycles per quarter-beat tick (8 ticks/s at 100 MHz); must be >= 2.
- INTRO_LEN, 64, quarter-beats in intro section (1..256).
- BODY_LEN, 128, quarter-beats in body section (1..256).
- OUTRO_LEN, 64, quarter-beats in outro section (1..256).
- SILENCE, 32'd20000, tone value meaning "no sound" (above audible range).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- start  input  1  single-cycle pulse; begin playback from intro beat 0
- stop  input  1  single-cycle pulse; abort playback immediately
- pause  input  1  level; freeze playback while high
- loop_en  input  1  level; repeat body instead of entering outro
- tone_intro  input  32  tone from intro ROM at beat_num
- tone_body  input  32  tone from body ROM at beat_num
- tone_outro  input  32  tone from outro ROM at beat_num
- beat_num  output  8  current quarter-beat index within section (registered)
- section  output  2  0=IDLE, 1=INTRO, 2=BODY, 3=OUTRO (registered)
- tone  output  32  selected tone to tone generator (combinational from registered state)
- playing  output  1  high whenever section != IDLE
- done  output  1  one-cycle pulse when outro completes normally

Behaviour:
- Reset (async, rst=1): section=IDLE, beat_num=0, divider=0, done=0; tone=SILENCE, playing=0.
- Divider: counts 0..BEAT_DIV-1 only when section!=IDLE and pause=0. At BEAT_DIV-1 a tick occurs and the divider wraps to 0. Its width is clog2(BEAT_DIV).
- On tick, beat_num increments unless at section end (beat_num==LEN-1). At section end, beat_num goes to 0 and:
  - INTRO -> BODY.
  - BODY -> BODY if loop_en=1 at the tick, else OUTRO.
  - OUTRO -> IDLE, with done=1 for exactly that one cycle.
- IDLE + start: next cycle section=INTRO, beat_num=0, divider=0.
- start while not IDLE is ignored; no restart.
- stop in any non-IDLE state: next cycle section=IDLE, beat_num=0, divider=0, no done pulse.
- Priority: stop > start > tick. stop and start in the same cycle from IDLE leaves the block in IDLE.
- pause=1: divider and beat_num hold, tone=SILENCE. On release, counting resumes from the held divider value; no tick is lost or duplicated.
- pause asserted in IDLE has no effect. start while paused is accepted, but the block stays frozen at INTRO beat 0 until pause=0.
- tone mux:
  - IDLE or paused: SILENCE.
  - INTRO: tone_intro.
  - BODY: tone_body.
  - OUTRO: tone_outro.
- ROM latency is zero, so tone reflects the new beat_num in the same cycle beat_num changes.
- beat_num never exceeds LEN-1 of the current section. A mid-sequence reset returns to IDLE asynchronously.

Optional Feature:
- Macro NOTE_GAP_EN.
- Defined: tone is forced to SILENCE while divider >= BEAT_DIV - BEAT_DIV/8 (minimum 1 cycle) in every playing section. This inserts a short articulation gap so repeated equal notes are audible as separate notes.
- Undefined: tone is continuous across ticks, with no gap.

Test Plan (BEAT_DIV=4, INTRO_LEN=4, BODY_LEN=8, OUTRO_LEN=4, tone_intro=523, tone_body=880, tone_outro=1046):
- Reset then start pulse, loop_en=0:
  - section 1 for 16 cycles with beat_num 0..3, tone=523.
  - then section 2 for 32 cycles, tone=880.
  - then section 3 for 16 cycles, tone=1046.
  - then section 0 with a done pulse exactly 1 cycle, tone=20000.
- loop_en=1 during body: at body beat 7 tick, section stays 2 and beat_num returns to 0. Drop loop_en, and the next body end enters section 3.
- Pause for 10 cycles at intro beat 2, divider 1: beat_num stays 2 and tone=20000. After release, beat 3 arrives exactly 3 cycles later.
- stop during body beat 5: next cycle section=0, beat_num=0, tone=20000, done never asserts.
- Same-cycle stop+start in IDLE: stays IDLE. start pulse during OUTRO: ignored, and the sequence completes with done.
- NOTE_GAP_EN defined: in each 4-cycle beat, the last cycle shows tone=20000 and the first 3 show the section tone. Undefined: all 4 cycles show the section tone.
